// File: rtl/dll_pkg.sv
// Shared constants and types for the Data Link Layer transmit path.
// Frames are 136 bits: a 128-bit payload in [135:8] and a frame type code in [7:0].
package dll_pkg;

  localparam int FRAME_W = 136;

  localparam logic [1:0] DLC_DL_INACTIVE = 2'b00;
  localparam logic [1:0] DLC_DL_FEATURE  = 2'b01;
  localparam logic [1:0] DLC_DL_INIT     = 2'b10;
  localparam logic [1:0] DLC_DL_ACTIVE   = 2'b11;

  localparam logic [7:0] FRM_TLP    = 8'h01;
  localparam logic [7:0] FRM_ACKNAK = 8'h02;
  localparam logic [7:0] FRM_FC     = 8'h03;

  localparam logic [7:0] DLLP_ACK = 8'h00;
  localparam logic [7:0] DLLP_NAK = 8'h10;

  typedef enum logic [0:0] {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_e;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_TLP    = 2'd1,
    GNT_ACKNAK = 2'd2,
    GNT_FC     = 2'd3
  } gnt_sel_e;

endpackage

// File: rtl/dll_tx_arb_if.sv
// Requester, DLCMSM and PHY-side signals of the DLL transmit arbiter.
// master = the arbiter itself, slave = the surrounding requesters and PHY.
interface dll_tx_arb_if;
  logic [1:0]   dlc_state_i;
  logic [127:0] tlp_i;
  logic         tlp_valid_i;
  logic         tlp_ready_o;
  logic         acknak_req_i;
  logic         acknak_is_nak_i;
  logic [11:0]  acknak_seq_i;
  logic         acknak_gnt_o;
  logic         fc_req_i;
  logic [7:0]   fc_type_i;
  logic [23:0]  fc_body_i;
  logic         fc_gnt_o;
  logic [135:0] dllp_o;
  logic         dllp_valid_o;
  logic         phy_ready_i;

  modport master (
    input  dlc_state_i, tlp_i, tlp_valid_i, acknak_req_i, acknak_is_nak_i,
           acknak_seq_i, fc_req_i, fc_type_i, fc_body_i, phy_ready_i,
    output tlp_ready_o, acknak_gnt_o, fc_gnt_o, dllp_o, dllp_valid_o
  );

  modport slave (
    output dlc_state_i, tlp_i, tlp_valid_i, acknak_req_i, acknak_is_nak_i,
           acknak_seq_i, fc_req_i, fc_type_i, fc_body_i, phy_ready_i,
    input  tlp_ready_o, acknak_gnt_o, fc_gnt_o, dllp_o, dllp_valid_o
  );
endinterface

// File: rtl/dll_tx_frame_fmt.sv
// Combinational frame builder: selects the granted requester's payload and
// packs it into the 136-bit PHY frame with its frame type code in [7:0].
module dll_tx_frame_fmt
  import dll_pkg::*;
(
  input  gnt_sel_e              sel,
  input  logic [127:0]          tlp,
  input  logic                  acknak_is_nak,
  input  logic [11:0]           acknak_seq,
  input  logic [7:0]            fc_type,
  input  logic [23:0]           fc_body,
  output logic [FRAME_W-1:0]    frame
);

  logic [7:0] acknak_type;

  assign acknak_type = acknak_is_nak ? DLLP_NAK : DLLP_ACK;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    frame = '0;
    case (sel)
      GNT_TLP:    frame = {tlp, FRM_TLP};
      // DLLP frames are zero-extended to the 128-bit payload field.
      GNT_ACKNAK: frame = {88'd0, 20'd0, acknak_seq, acknak_type, FRM_ACKNAK};
      GNT_FC:     frame = {96'd0, fc_body, fc_type, FRM_FC};
      default:    frame = '0;
    endcase
  end

endmodule

// File: rtl/dll_tx_arb.sv
// DLL transmit arbiter: state-gated fixed-priority arbitration (Ack/Nak > FC > TLP)
// with a TLP anti-starvation guard, feeding a one-entry registered PHY output stage.
module dll_tx_arb
  import dll_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  dll_tx_arb_if.master  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  out_state_e          out_state;
  gnt_sel_e            held_sel;
  gnt_sel_e            gnt_sel;
  logic [FRAME_W-1:0]  dllp_q;
  logic [FRAME_W-1:0]  frame;
  logic [3:0]          starve_cnt;

  logic tlp_elig, acknak_elig, fc_elig;
  logic tlp_wait, force_tlp, slot_free, dllp_gnt, drop_held;

  assign tlp_elig    = (bus.dlc_state_i == DLC_DL_ACTIVE);
  assign acknak_elig = (bus.dlc_state_i == DLC_DL_ACTIVE);
  assign fc_elig     = (bus.dlc_state_i == DLC_DL_ACTIVE) || (bus.dlc_state_i == DLC_DL_INIT);

  assign tlp_wait  = bus.tlp_valid_i && tlp_elig;
  assign force_tlp = tlp_wait && (starve_cnt == STARVE_LIM);
  assign slot_free = (out_state == OUT_IDLE) || bus.phy_ready_i;

  // Grants are suppressed during reset so every output reads 0 while rst is high.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (!rst && slot_free) begin
      if (force_tlp)                        gnt_sel = GNT_TLP;
      else if (acknak_elig && bus.acknak_req_i) gnt_sel = GNT_ACKNAK;
      else if (fc_elig && bus.fc_req_i)     gnt_sel = GNT_FC;
      else if (tlp_wait)                    gnt_sel = GNT_TLP;
    end
  end

  assign dllp_gnt = (gnt_sel == GNT_ACKNAK) || (gnt_sel == GNT_FC);

  // TLP and Ack/Nak frames are only meaningful in ACTIVE; FC frames survive into INIT.
  assign drop_held = (out_state == OUT_HOLD) && (bus.dlc_state_i != DLC_DL_ACTIVE) &&
                     ((held_sel == GNT_TLP) || (held_sel == GNT_ACKNAK));

  dll_tx_frame_fmt u_fmt (
    .sel           (gnt_sel),
    .tlp           (bus.tlp_i),
    .acknak_is_nak (bus.acknak_is_nak_i),
    .acknak_seq    (bus.acknak_seq_i),
    .fc_type       (bus.fc_type_i),
    .fc_body       (bus.fc_body_i),
    .frame         (frame)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus.tlp_valid_i || (gnt_sel == GNT_TLP)) begin
      starve_cnt <= '0;
    end else if (dllp_gnt && tlp_wait && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state <= OUT_IDLE;
      held_sel  <= GNT_NONE;
      dllp_q    <= '0;
    end else if (gnt_sel != GNT_NONE) begin
      out_state <= OUT_HOLD;
      held_sel  <= gnt_sel;
      dllp_q    <= frame;
    end else if ((out_state == OUT_HOLD) && (bus.phy_ready_i || drop_held)) begin
      out_state <= OUT_IDLE;
      held_sel  <= GNT_NONE;
    end
  end

  assign bus.dllp_o       = dllp_q;
  assign bus.dllp_valid_o = (out_state == OUT_HOLD);
  assign bus.tlp_ready_o  = (gnt_sel == GNT_TLP);
  assign bus.acknak_gnt_o = (gnt_sel == GNT_ACKNAK);
  assign bus.fc_gnt_o     = (gnt_sel == GNT_FC);

endmodule

// File: tb/tb_dll_tx_arb.sv
// Directed, table-driven bench for dll_tx_arb plus hand-written multi-cycle
// sequences for starvation, back-pressure, state drop and reset mid-HOLD.
module tb_dll_tx_arb;
  import dll_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dll_tx_arb_if bus ();

  dll_tx_arb #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] TLP_PAY = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [11:0]  SEQ_A   = 12'h123;
  localparam logic [7:0]   FC_TYP  = 8'h50;
  localparam logic [23:0]  FC_BODY = 24'hA5C3E1;

  // req = {tlp_valid, acknak_req, fc_req, phy_ready}; exp = {tlp_ready, acknak_gnt, fc_gnt, valid after edge}
  typedef struct {
    logic [1:0] dlc;
    logic [3:0] req;
    logic [3:0] exp;
    logic [7:0] code;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [1:0] d, input logic [3:0] r, input logic [3:0] e,
                             input logic [7:0] c);
    vec_t t;
    t.dlc = d; t.req = r; t.exp = e; t.code = c;
    return t;
  endfunction

  function automatic logic [135:0] exp_frame(input logic [7:0] code, input logic nak,
                                             input logic [11:0] seq);
    case (code)
      8'h01:   return {TLP_PAY, 8'h01};
      8'h02:   return {108'd0, seq, (nak ? 8'h10 : 8'h00), 8'h02};
      8'h03:   return {96'd0, FC_BODY, FC_TYP, 8'h03};
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic [1:0] d, input logic [3:0] r);
    bus.dlc_state_i  = d;
    bus.tlp_valid_i  = r[3];
    bus.acknak_req_i = r[2];
    bus.fc_req_i     = r[1];
    bus.phy_ready_i  = r[0];
  endtask

  task automatic check_gnts(input string tag, input logic [2:0] e);
    check({tag, " tlp_ready"},  136'(bus.tlp_ready_o),  136'(e[2]));
    check({tag, " acknak_gnt"}, 136'(bus.acknak_gnt_o), 136'(e[1]));
    check({tag, " fc_gnt"},     136'(bus.fc_gnt_o),     136'(e[0]));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [135:0] held;

  initial begin
    bus.tlp_i           = TLP_PAY;
    bus.acknak_is_nak_i = 1'b0;
    bus.acknak_seq_i    = SEQ_A;
    bus.fc_type_i       = FC_TYP;
    bus.fc_body_i       = FC_BODY;
    drive(DLC_DL_INACTIVE, 4'b0000);

    vecs[0]  = v(DLC_DL_ACTIVE,   4'b1111, 4'b0101, 8'h02);
    vecs[1]  = v(DLC_DL_ACTIVE,   4'b1011, 4'b0011, 8'h03);
    vecs[2]  = v(DLC_DL_ACTIVE,   4'b1001, 4'b1001, 8'h01);
    vecs[3]  = v(DLC_DL_ACTIVE,   4'b0001, 4'b0000, 8'h00);
    vecs[4]  = v(DLC_DL_INIT,     4'b1011, 4'b0011, 8'h03);
    vecs[5]  = v(DLC_DL_INIT,     4'b1001, 4'b0000, 8'h00);
    vecs[6]  = v(DLC_DL_INIT,     4'b1101, 4'b0000, 8'h00);
    vecs[7]  = v(DLC_DL_ACTIVE,   4'b1001, 4'b1001, 8'h01);
    vecs[8]  = v(DLC_DL_INACTIVE, 4'b1111, 4'b0000, 8'h00);
    vecs[9]  = v(DLC_DL_FEATURE,  4'b1111, 4'b0000, 8'h00);
    vecs[10] = v(DLC_DL_ACTIVE,   4'b0111, 4'b0101, 8'h02);
    vecs[11] = v(DLC_DL_ACTIVE,   4'b0011, 4'b0011, 8'h03);
    vecs[12] = v(DLC_DL_ACTIVE,   4'b0001, 4'b0000, 8'h00);

    // Reset state.
    #3;
    check("reset dllp_valid", 136'(bus.dllp_valid_o), 136'd0);
    check("reset dllp_o", bus.dllp_o, 136'd0);
    check_gnts("reset", 3'b000);
    #9 rst = 1'b0;
    tick();

    // Table: priority, state eligibility, latency and frame formats.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].dlc, vecs[i].req);
      #1;
      check_gnts($sformatf("row%0d", i), vecs[i].exp[3:1]);
      tick();
      check($sformatf("row%0d dllp_valid", i), 136'(bus.dllp_valid_o), 136'(vecs[i].exp[0]));
      if (vecs[i].exp[0])
        check($sformatf("row%0d dllp_o", i), bus.dllp_o, exp_frame(vecs[i].code, 1'b0, SEQ_A));
    end

    // Anti-starvation: four Ack/Nak grants, then the waiting TLP, then Ack/Nak again.
    begin
      logic [2:0] pat [6];
      pat = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b010};
      for (int c = 0; c < 6; c++) begin
        drive(DLC_DL_ACTIVE, 4'b1101);
        #1;
        check_gnts($sformatf("starve c%0d", c), pat[c]);
        tick();
      end
      drive(DLC_DL_ACTIVE, 4'b0001);
      tick();
    end

    // Back-pressure: held frame stable for 5 cycles, then back-to-back reload.
    drive(DLC_DL_ACTIVE, 4'b0101);
    tick();
    held = exp_frame(8'h02, 1'b0, SEQ_A);
    for (int c = 0; c < 5; c++) begin
      drive(DLC_DL_ACTIVE, 4'b0010);
      #1;
      check_gnts($sformatf("stall c%0d", c), 3'b000);
      tick();
      check($sformatf("stall c%0d dllp_valid", c), 136'(bus.dllp_valid_o), 136'd1);
      check($sformatf("stall c%0d dllp_o", c), bus.dllp_o, held);
    end
    drive(DLC_DL_ACTIVE, 4'b0011);
    #1;
    check_gnts("stall release", 3'b001);
    tick();
    check("b2b dllp_valid", 136'(bus.dllp_valid_o), 136'd1);
    check("b2b dllp_o", bus.dllp_o, exp_frame(8'h03, 1'b0, SEQ_A));
    drive(DLC_DL_ACTIVE, 4'b0001);
    tick();

    // State drop: a held TLP is discarded when the link leaves ACTIVE.
    drive(DLC_DL_ACTIVE, 4'b1001);
    tick();
    check("drop pre dllp_valid", 136'(bus.dllp_valid_o), 136'd1);
    drive(DLC_DL_INACTIVE, 4'b1100);
    #1;
    check_gnts("drop", 3'b000);
    tick();
    check("drop dllp_valid", 136'(bus.dllp_valid_o), 136'd0);
    drive(DLC_DL_INACTIVE, 4'b1101);
    #1;
    check_gnts("drop idle", 3'b000);
    tick();
    check("drop idle dllp_valid", 136'(bus.dllp_valid_o), 136'd0);

    // A held FC frame survives ACTIVE -> INIT.
    drive(DLC_DL_ACTIVE, 4'b0011);
    tick();
    drive(DLC_DL_INIT, 4'b0000);
    tick();
    check("fc keep dllp_valid", 136'(bus.dllp_valid_o), 136'd1);
    check("fc keep dllp_o", bus.dllp_o, exp_frame(8'h03, 1'b0, SEQ_A));
    drive(DLC_DL_INIT, 4'b0001);
    tick();
    check("fc drain dllp_valid", 136'(bus.dllp_valid_o), 136'd0);

    // Nak frame layout, then reset asserted mid-HOLD.
    bus.acknak_is_nak_i = 1'b1;
    bus.acknak_seq_i    = 12'hABC;
    drive(DLC_DL_ACTIVE, 4'b0100);
    #1;
    check_gnts("nak", 3'b010);
    tick();
    check("nak dllp_o", bus.dllp_o, {108'd0, 12'hABC, 8'h10, 8'h02});
    check("nak type byte", 136'(bus.dllp_o[15:8]), 136'h10);
    check("nak seq field", 136'(bus.dllp_o[27:16]), 136'hABC);
    #2 rst = 1'b1;
    #1;
    check("rst dllp_valid", 136'(bus.dllp_valid_o), 136'd0);
    check("rst dllp_o", bus.dllp_o, 136'd0);
    check_gnts("rst", 3'b000);
    @(negedge clk);
    rst = 1'b0;
    drive(DLC_DL_INACTIVE, 4'b0000);
    tick();
    check("post rst dllp_valid", 136'(bus.dllp_valid_o), 136'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
